// File: rtl/nco_freq_gen_if.sv
// rtl/nco_freq_gen_if.sv - frequency request / increment response bundle for nco_freq_gen
interface nco_freq_gen_if #(
  parameter int FREQ_W = 20,
  parameter int ACC_W  = 32
);
  logic [FREQ_W-1:0] freq_hz;
  logic              freq_load;
  logic              ready;
  logic              err;
  logic [ACC_W-1:0]  inc_word;

  modport master (
    output freq_hz, freq_load,
    input  ready, err, inc_word
  );

  modport slave (
    input  freq_hz, freq_load,
    output ready, err, inc_word
  );
endinterface

// File: rtl/nco_freq_gen.sv
// rtl/nco_freq_gen.sv - Hz-programmed phase-accumulator square-wave source with serial divider
// Optional PRBS_EN adds a 7-bit LFSR stepped on each rising output edge.
module nco_freq_gen #(
  parameter int SYS_CLK_FREQ = 2000000,
  parameter int FREQ_W       = 20,
  parameter int ACC_W        = 32
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  nco_freq_gen_if.slave       req,
  input  logic                enable,
  output logic                clk_out,
  output logic                edge_pulse,
  output logic                prbs_out
);
  localparam int DIV_W = $clog2(SYS_CLK_FREQ + 1);
  localparam int REM_W = DIV_W + 1;
  localparam int DVD_W = FREQ_W + ACC_W;
  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [REM_W-1:0]  DIVISOR = REM_W'(SYS_CLK_FREQ);
  localparam logic [FREQ_W-1:0] F_MAX   = FREQ_W'(SYS_CLK_FREQ / 2);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_APPLY} state_t;

  state_t            state;
  logic [DVD_W-1:0]  dvd;
  logic [REM_W-1:0]  rem;
  logic [ACC_W-1:0]  quo;
  logic [CNT_W-1:0]  cnt;
  logic              ready_r;
  logic              err_r;
  logic [ACC_W-1:0]  inc_word_r;

  logic [REM_W-1:0]  rem_sh;
  logic [REM_W-1:0]  rem_diff;
  logic              q_bit;

  assign req.ready    = ready_r;
  assign req.err      = err_r;
  assign req.inc_word = inc_word_r;

  // Restoring step: remainder stays below the divisor, so one extra bit holds the shifted trial.
  always_comb begin
    rem_sh   = {rem[REM_W-2:0], dvd[DVD_W-1]};
    rem_diff = rem_sh - DIVISOR;
    q_bit    = (rem_sh >= DIVISOR);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dvd        <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      ready_r    <= 1'b1;
      err_r      <= 1'b0;
      inc_word_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req.freq_load) begin
            if (req.freq_hz > F_MAX) begin
              err_r <= 1'b1;
            end else begin
              err_r   <= 1'b0;
              dvd     <= {req.freq_hz, {ACC_W{1'b0}}};
              rem     <= '0;
              quo     <= '0;
              cnt     <= '0;
              ready_r <= 1'b0;
              state   <= S_DIV;
            end
          end
        end
        S_DIV: begin
          rem <= q_bit ? rem_diff : rem_sh;
          // Quotient bits above ACC_W are always zero for legal requests and drop off the top.
          quo <= {quo[ACC_W-2:0], q_bit};
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DVD_W - 1))
            state <= S_APPLY;
        end
        S_APPLY: begin
          inc_word_r <= quo;
          ready_r    <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  assign acc_next = acc + inc_word_r;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      clk_out    <= 1'b0;
      edge_pulse <= 1'b0;
    end else if (!enable) begin
      acc        <= '0;
      clk_out    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      acc        <= acc_next;
      clk_out    <= acc_next[ACC_W-1];
      edge_pulse <= acc_next[ACC_W-1] & ~clk_out;
    end
  end

`ifdef PRBS_EN
  logic [6:0] lfsr;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= 7'h7F;
      prbs_out <= 1'b0;
    end else begin
      if (!enable)
        lfsr <= 7'h7F;
      else if (edge_pulse)
        lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      prbs_out <= lfsr[6];
    end
  end
`else
  assign prbs_out = 1'b0;
`endif

endmodule

// File: tb/tb_nco_freq_gen.sv
// tb/tb_nco_freq_gen.sv - directed scoreboard bench for nco_freq_gen
module tb_nco_freq_gen;
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic enable  = 1'b0;
  logic clk_out, edge_pulse, prbs_out;

  nco_freq_gen_if #(.FREQ_W(20), .ACC_W(32)) ifc ();

  nco_freq_gen #(.SYS_CLK_FREQ(2000000), .FREQ_W(20), .ACC_W(32)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .req        (ifc),
    .enable     (enable),
    .clk_out    (clk_out),
    .edge_pulse (edge_pulse),
    .prbs_out   (prbs_out)
  );

  always #250 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe a request; optionally fire a second strobe intr_at cycles into the busy window.
  task automatic do_load(input logic [19:0] f, input int intr_at, output int lowc);
    logic [63:0] q;
    ifc.freq_hz   = f;
    ifc.freq_load = 1'b1;
    if (f <= 20'd1000000) begin
      q = ({12'b0, f, 32'b0}) / 64'd2000000;
      exp_q.push_back(q[31:0]);
    end
    @(negedge sys_clk);
    ifc.freq_load = 1'b0;
    lowc = 0;
    while (ifc.ready !== 1'b1 && lowc < 200) begin
      lowc++;
      if (lowc == intr_at) begin
        ifc.freq_hz   = 20'd1000;
        ifc.freq_load = 1'b1;
      end else begin
        ifc.freq_load = 1'b0;
      end
      @(negedge sys_clk);
    end
    ifc.freq_load = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    chk({tag, "_sb_has_entry"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, 64'(ifc.inc_word), 64'(e));
    end
  endtask

  initial begin
    int lowc, edges, hi, tog, ones;
    logic prev;
    logic samp [0:253];
    int ns;

    ifc.freq_hz   = '0;
    ifc.freq_load = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", 64'(ifc.ready), 64'd1);
    chk("rst_err",   64'(ifc.err), 64'd0);
    chk("rst_inc",   64'(ifc.inc_word), 64'd0);
    chk("rst_clk",   64'(clk_out), 64'd0);
    chk("rst_edge",  64'(edge_pulse), 64'd0);
    chk("rst_prbs",  64'(prbs_out), 64'd0);

    rst_n  = 1'b1;
    enable = 1'b1;
    edges = 0; hi = 0;
    repeat (1000) begin
      @(negedge sys_clk);
      edges += int'(edge_pulse);
      hi    += int'(clk_out);
    end
    chk("idle_edges", 64'(edges), 64'd0);
    chk("idle_clk_hi", 64'(hi), 64'd0);
    chk("idle_inc", 64'(ifc.inc_word), 64'd0);

    do_load(20'd100000, -1, lowc);
    chk("lat_100k", 64'(lowc), 64'd53);
    pop_chk("inc_100k");
    chk("inc_100k_const", 64'(ifc.inc_word), 64'h0CCCCCCC);
    chk("err_100k", 64'(ifc.err), 64'd0);

    enable = 1'b0;
    @(negedge sys_clk);
    chk("dis_clk", 64'(clk_out), 64'd0);
    chk("dis_edge", 64'(edge_pulse), 64'd0);
    enable = 1'b1;
    edges = 0; ones = 0;
    repeat (20000) begin
      @(negedge sys_clk);
      edges += int'(edge_pulse);
      ones  += int'(prbs_out);
    end
    chk("edges_20k_in_range", 64'(edges >= 999 && edges <= 1000), 64'd1);
`ifndef PRBS_EN
    chk("prbs_off_zero", 64'(ones), 64'd0);
`endif

    do_load(20'd1, -1, lowc);
    chk("lat_1", 64'(lowc), 64'd53);
    pop_chk("inc_1");
    chk("inc_1_const", 64'(ifc.inc_word), 64'd2147);

    do_load(20'd1000000, -1, lowc);
    pop_chk("inc_1m");
    chk("inc_1m_const", 64'(ifc.inc_word), 64'h80000000);
    prev = clk_out; tog = 0; edges = 0;
    repeat (16) begin
      @(negedge sys_clk);
      if (clk_out !== prev) tog++;
      edges += int'(edge_pulse);
      prev = clk_out;
    end
    chk("toggle_1m", 64'(tog), 64'd16);
    chk("edges_1m", 64'(edges), 64'd8);

    do_load(20'd1000001, -1, lowc);
    chk("too_fast_err", 64'(ifc.err), 64'd1);
    chk("too_fast_ready_low", 64'(lowc), 64'd0);
    chk("too_fast_inc_kept", 64'(ifc.inc_word), 64'h80000000);
    chk("too_fast_no_sb", 64'(exp_q.size()), 64'd0);

    do_load(20'd100000, -1, lowc);
    chk("err_cleared", 64'(ifc.err), 64'd0);
    pop_chk("inc_after_err");

    do_load(20'd1, 10, lowc);
    chk("lat_interfered", 64'(lowc), 64'd53);
    pop_chk("inc_interfered");
    chk("err_interfered", 64'(ifc.err), 64'd0);

    do_load(20'd0, -1, lowc);
    pop_chk("inc_0");
    prev = clk_out; tog = 0; edges = 0;
    repeat (200) begin
      @(negedge sys_clk);
      if (clk_out !== prev) tog++;
      edges += int'(edge_pulse);
    end
    chk("zero_edges", 64'(edges), 64'd0);
    chk("zero_hold", 64'(tog), 64'd0);

    ifc.freq_hz   = 20'd100000;
    ifc.freq_load = 1'b1;
    @(negedge sys_clk);
    ifc.freq_load = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("mid_div_busy", 64'(ifc.ready), 64'd0);
    rst_n = 1'b0;
    #10;
    chk("mid_div_rst_ready", 64'(ifc.ready), 64'd1);
    chk("mid_div_rst_inc", 64'(ifc.inc_word), 64'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (60) @(negedge sys_clk);
    chk("post_rst_inc", 64'(ifc.inc_word), 64'd0);
    chk("post_rst_ready", 64'(ifc.ready), 64'd1);

    do_load(20'd500000, -1, lowc);
    pop_chk("inc_500k");
    enable = 1'b0;
    @(negedge sys_clk);
    enable = 1'b1;
    ns = 0; lowc = 0; ones = 0;
    while (ns < 254 && lowc < 3000) begin
      @(negedge sys_clk);
      lowc++;
      ones += int'(prbs_out);
      if (edge_pulse) begin
        samp[ns] = prbs_out;
        ns++;
      end
    end
    chk("prbs_samples", 64'(ns), 64'd254);
`ifdef PRBS_EN
    tog = 0; hi = 0;
    for (int i = 0; i < 127; i++) begin
      if (samp[i] !== samp[i+127]) tog++;
      hi += int'(samp[i]);
    end
    chk("prbs_period", 64'(tog), 64'd0);
    chk("prbs_ones", 64'(hi), 64'd64);
`else
    chk("prbs_off_zero_500k", 64'(ones), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
